// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall, flush, freeze, watchdog and HLT drain control.
// Optional perf counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_halt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_write_en,
  output logic        if_id_write_en,
  output logic        if_id_flush,
  output logic        id_ex_write_en,
  output logic        id_ex_flush,
  output logic        ex_mem_write_en,
  output logic        mem_wb_write_en,
  output logic        halted,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [3:0]  DRAIN_INIT = 4'(DRAIN_CYCLES);
  localparam logic [15:0] BUSY_MAX   = 16'(MEM_TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [15:0] busy_q, busy_d;
  logic        tmo_q, tmo_d;

  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic br_acc;

  // Register 31 reads as zero, so a load into it never creates a hazard.
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != 5'd31)
                    && (rs1_hit || rs2_hit);

  // Control outputs and FSM next state by priority.
  always_comb begin
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_write_en  = 1'b1;
    id_ex_flush     = 1'b0;
    ex_mem_write_en = 1'b1;
    mem_wb_write_en = 1'b1;
    state_d         = state_q;
    drain_d         = drain_q;
    br_acc          = 1'b0;
    if (reset || mem_busy || state_q == S_HALT) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_acc      = 1'b1;
          end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
          end else if (id_halt) begin
            pc_write_en = 1'b0;
            if_id_flush = 1'b1;
            state_d     = S_DRAIN;
            drain_d     = DRAIN_INIT;
          end
        end
        S_DRAIN: begin
          pc_write_en = 1'b0;
          if_id_flush = 1'b1;
          drain_d     = drain_q - 4'd1;
          if (drain_q == 4'd1) begin
            state_d = S_HALT;
          end
        end
        default: begin
          pc_write_en     = 1'b0;
          if_id_write_en  = 1'b0;
          id_ex_write_en  = 1'b0;
          ex_mem_write_en = 1'b0;
          mem_wb_write_en = 1'b0;
          state_d         = S_RUN;
        end
      endcase
    end
  end

  // Watchdog: count consecutive busy cycles, latch error at the limit.
  always_comb begin
    busy_d = 16'd0;
    if (mem_busy) begin
      busy_d = (busy_q == BUSY_MAX) ? busy_q : busy_q + 16'd1;
    end
    tmo_d = tmo_q || (mem_busy && busy_d == BUSY_MAX);
  end

  // FSM, drain and watchdog state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      drain_q <= 4'd0;
      busy_q  <= 16'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign halted      = (state_q == S_HALT);
  assign mem_timeout = tmo_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;
  logic        stall_ev;

  // Any live-state cycle that holds the PC counts as a stall.
  assign stall_ev = (state_q != S_HALT) && !pc_write_en;

  // Saturating perf counter next values.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_ev && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
    if (br_acc && flush_q != 32'hFFFF_FFFF) begin
      flush_d = flush_q + 32'd1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  logic unused_br;
  assign unused_br    = br_acc;
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule
